// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings and widths for the hazard/forwarding unit and its scoreboard.
package hazard_fwd_unit_pkg;

    localparam int FWD_RF        = 0;
    localparam int FWD_STAGE_OFS = 1;
    localparam int SB_CNT_W      = 4;
    localparam int STALL_CNT_W   = 32;

    // Select code for downstream stage k (0 = nearest).
    function automatic int fwd_code(input int stage);
        return stage + FWD_STAGE_OFS;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for long-latency writes; busy while count is nonzero.
import hazard_fwd_unit_pkg::*;

module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LONG_LAT   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     long_issue,
    input  logic [REG_ADDR_W-1:0]    long_dest,
    output logic [2**REG_ADDR_W-1:0] busy
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    // Register 0 is never written, so it can never be busy.
    assign busy[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic [SB_CNT_W-1:0] cnt_reg;

            // A fresh issue takes priority over the running countdown.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (long_issue && long_dest == REG_ADDR_W'(gi)) begin
                    cnt_reg <= SB_CNT_W'(LONG_LAT);
                end else if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - SB_CNT_W'(1);
                end
            end

            assign busy[gi] = (cnt_reg != '0);
        end
    endgenerate

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX-stage operand forwarding, load-use and scoreboard stall detection, stall-cycle counter.
import hazard_fwd_unit_pkg::*;

module hazard_fwd_unit #(
    parameter int                     REG_ADDR_W    = 5,
    parameter int                     NUM_SRC       = 2,
    parameter int                     NUM_FWD       = 2,
    parameter int                     LONG_LAT      = 4,
    parameter int                     SEL_W         = $clog2(NUM_FWD + 1),
    parameter logic [STALL_CNT_W-1:0] STALL_CNT_RST = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
    input  logic [NUM_SRC-1:0]            ex_src_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_dest,
    input  logic [NUM_FWD-1:0]            fwd_reg_write,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_valid,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_reg_write,
    input  logic [REG_ADDR_W-1:0]         ex_dest,
    input  logic                          ex_mem_read,
    input  logic                          long_issue,
    input  logic [REG_ADDR_W-1:0]         long_dest,
    output logic                          stall,
    output logic [STALL_CNT_W-1:0]        stall_cnt
);

    logic [2**REG_ADDR_W-1:0] busy;
    logic [NUM_SRC-1:0]       load_use_hit;
    logic [NUM_SRC-1:0]       raw_hit;
    logic                     load_use;
    logic                     raw;
    logic                     waw;
    logic [STALL_CNT_W-1:0]   stall_cnt_reg;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .LONG_LAT   (LONG_LAT)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .long_issue (long_issue),
        .long_dest  (long_dest),
        .busy       (busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            logic [REG_ADDR_W-1:0] src;
            logic [SEL_W-1:0]      sel;

            assign src = ex_src[gi*REG_ADDR_W +: REG_ADDR_W];

            // Scan farthest to nearest so the nearest matching stage overwrites.
            always_comb begin
                sel = SEL_W'(FWD_RF);
                if (ex_src_valid[gi] && src != '0) begin
                    for (int k = NUM_FWD - 1; k >= 0; k--) begin
                        if (fwd_reg_write[k] && fwd_dest[k*REG_ADDR_W +: REG_ADDR_W] == src) begin
                            sel = SEL_W'(fwd_code(k));
                        end
                    end
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
        end

        for (gi = 0; gi < NUM_SRC; gi++) begin : g_id
            logic [REG_ADDR_W-1:0] src;

            assign src              = id_src[gi*REG_ADDR_W +: REG_ADDR_W];
            assign load_use_hit[gi] = id_src_valid[gi] && (src == ex_dest);
            assign raw_hit[gi]      = id_src_valid[gi] && busy[src];
        end
    endgenerate

    assign load_use = ex_mem_read && (ex_dest != '0) && (|load_use_hit);
    assign raw      = |raw_hit;
    assign waw      = id_reg_write && busy[id_dest];
    assign stall    = load_use || raw || waw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= STALL_CNT_RST;
        end else if (stall && stall_cnt_reg != '1) begin
            stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: vector table, directed multi-cycle sequences, random vs. model.
module tb_hazard_fwd_unit;

    localparam int W        = 5;
    localparam int NS       = 2;
    localparam int NF       = 2;
    localparam int LAT      = 4;
    localparam int SW       = 2;
    localparam logic [31:0] SAT_START = 32'hFFFF_FFFC;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     ex_s [NS];
    logic [NS-1:0]    ex_v;
    logic [W-1:0]     fd [NF];
    logic [NF-1:0]    fwr;
    logic [W-1:0]     id_s [NS];
    logic [NS-1:0]    id_v;
    logic [W-1:0]     idd;
    logic             id_wr;
    logic [W-1:0]     exd;
    logic             mr;
    logic             li;
    logic [W-1:0]     ld;

    logic [NS*SW-1:0] fwd_sel, fwd_sel_s;
    logic             stall, stall_s;
    logic [31:0]      stall_cnt, stall_cnt_s;

    logic [NS*W-1:0]  ex_src_bus, id_src_bus;
    logic [NF*W-1:0]  fwd_dest_bus;

    assign ex_src_bus   = {ex_s[1], ex_s[0]};
    assign id_src_bus   = {id_s[1], id_s[0]};
    assign fwd_dest_bus = {fd[1], fd[0]};

    hazard_fwd_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .NUM_FWD(NF), .LONG_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_src(ex_src_bus), .ex_src_valid(ex_v),
        .fwd_dest(fwd_dest_bus), .fwd_reg_write(fwr), .fwd_sel(fwd_sel),
        .id_src(id_src_bus), .id_src_valid(id_v), .id_dest(idd), .id_reg_write(id_wr),
        .ex_dest(exd), .ex_mem_read(mr), .long_issue(li), .long_dest(ld),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    // Second instance whose counter starts just below the maximum.
    hazard_fwd_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .NUM_FWD(NF), .LONG_LAT(LAT),
                      .STALL_CNT_RST(SAT_START)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .ex_src(ex_src_bus), .ex_src_valid(ex_v),
        .fwd_dest(fwd_dest_bus), .fwd_reg_write(fwr), .fwd_sel(fwd_sel_s),
        .id_src(id_src_bus), .id_src_valid(id_v), .id_dest(idd), .id_reg_write(id_wr),
        .ex_dest(exd), .ex_mem_read(mr), .long_issue(li), .long_dest(ld),
        .stall(stall_s), .stall_cnt(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: a register is busy for LAT cycles after the edge that issued it.
    int          edge_cnt = 0;
    int          issue_edge [32];
    logic [31:0] exp_cnt = 0;

    typedef struct {
        logic [W-1:0] es0, es1; logic [1:0] ev;
        logic [W-1:0] f0, f1;   logic [1:0] fw;
        logic [W-1:0] is0, is1; logic [1:0] iv;
        logic [W-1:0] xd;       logic       m;
        logic [1:0]   s0, s1;   logic       st;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_busy(input logic [W-1:0] r);
        if (r == 0) return 1'b0;
        return (edge_cnt - issue_edge[r]) < LAT;
    endfunction

    function automatic logic [1:0] m_fwd(input int i);
        if (!ex_v[i] || ex_s[i] == 0) return 2'd0;
        for (int k = 0; k < NF; k++)
            if (fwr[k] && fd[k] == ex_s[i]) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        logic lu, raw;
        lu  = 1'b0;
        raw = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (mr && exd != 0 && id_v[i] && id_s[i] == exd) lu = 1'b1;
            if (id_v[i] && m_busy(id_s[i])) raw = 1'b1;
        end
        return lu || raw || (id_wr && m_busy(idd));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) issue_edge[r] = -1000;
        exp_cnt = 0;
    endtask

    task automatic tick();
        logic st;
        st = m_stall();
        edge_cnt++;
        if (li && ld != 0) issue_edge[ld] = edge_cnt;
        if (st && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        for (int i = 0; i < NS; i++) begin ex_s[i] = 0; id_s[i] = 0; end
        for (int k = 0; k < NF; k++) fd[k] = 0;
        ex_v = 0; fwr = 0; id_v = 0; idd = 0; id_wr = 0;
        exd = 0; mr = 0; li = 0; ld = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        set_idle();
        model_reset();
        rst_n = 1'b0;
        #3;
        check("reset_fwd_sel", 32'(fwd_sel), 0);
        check("reset_stall", 32'(stall), 0);
        check("reset_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        //          es0 es1 ev   f0 f1 fw   is0 is1 iv  xd  m   s0 s1 st
        vecs[0] = '{5,  0,  1,   5, 5, 3,   0,  0,  0,  0,  0,  1, 0, 0};
        vecs[1] = '{5,  0,  1,   5, 5, 2,   0,  0,  0,  0,  0,  2, 0, 0};
        vecs[2] = '{0,  0,  1,   0, 0, 3,   0,  0,  0,  0,  0,  0, 0, 0};
        vecs[3] = '{5,  0,  0,   5, 5, 3,   0,  0,  0,  0,  0,  0, 0, 0};
        vecs[4] = '{6,  9,  3,   9, 6, 3,   0,  0,  0,  0,  0,  2, 1, 0};
        vecs[5] = '{0,  0,  0,   0, 0, 0,   0,  8,  2,  8,  1,  0, 0, 1};
        vecs[6] = '{0,  0,  0,   0, 0, 0,   0,  8,  0,  8,  1,  0, 0, 0};
        vecs[7] = '{0,  0,  0,   0, 0, 0,   0,  0,  1,  0,  1,  0, 0, 0};
        vecs[8] = '{0,  0,  0,   0, 0, 0,   0,  8,  2,  8,  0,  0, 0, 0};
        vecs[9] = '{0,  8,  2,   3, 8, 1,   8,  0,  1,  8,  1,  0, 0, 1};

        for (int v = 0; v < 10; v++) begin
            ex_s[0] = vecs[v].es0; ex_s[1] = vecs[v].es1; ex_v = vecs[v].ev;
            fd[0]   = vecs[v].f0;  fd[1]   = vecs[v].f1;  fwr  = vecs[v].fw;
            id_s[0] = vecs[v].is0; id_s[1] = vecs[v].is1; id_v = vecs[v].iv;
            exd     = vecs[v].xd;  mr      = vecs[v].m;
            #1;
            check($sformatf("vec%0d_sel0", v), 32'(fwd_sel[1:0]), 32'(vecs[v].s0));
            check($sformatf("vec%0d_sel1", v), 32'(fwd_sel[3:2]), 32'(vecs[v].s1));
            check($sformatf("vec%0d_stall", v), 32'(stall), 32'(vecs[v].st));
            tick();
        end
        check("vec_stall_cnt", stall_cnt, 2);

        // RAW on a long op: four stall cycles, then free.
        set_idle();
        do_reset();
        id_s[0] = 12; id_v = 1; li = 1; ld = 12;
        #1;
        check("raw_pre_issue", 32'(stall), 0);
        tick();
        li = 0; ld = 0;
        for (int c = 0; c < LAT; c++) begin
            #1;
            check($sformatf("raw_busy_c%0d", c), 32'(stall), 1);
            tick();
        end
        check("raw_free", 32'(stall), 0);
        check("raw_stall_cnt", stall_cnt, 4);

        // WAW plus reload two cycles after the first issue.
        set_idle();
        do_reset();
        idd = 3; id_wr = 1; li = 1; ld = 3;
        #1;
        check("waw_pre_issue", 32'(stall), 0);
        tick();
        li = 0;
        #1;
        check("waw_c0", 32'(stall), 1);
        tick();
        li = 1;
        #1;
        check("waw_c1", 32'(stall), 1);
        tick();
        li = 0;
        for (int c = 0; c < LAT; c++) begin
            #1;
            check($sformatf("waw_reload_c%0d", c), 32'(stall), 1);
            tick();
        end
        check("waw_free", 32'(stall), 0);
        check("waw_stall_cnt", stall_cnt, 6);

        // Issue to r0 is ignored.
        set_idle();
        idd = 0; id_wr = 1; id_s[0] = 0; id_v = 1; li = 1; ld = 0;
        tick();
        li = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("r0_c%0d", c), 32'(stall), 0);
            tick();
        end

        // Saturation on the preset instance: hold a load-use stall.
        set_idle();
        do_reset();
        mr = 1; exd = 8; id_s[0] = 8; id_v = 1;
        for (int n = 0; n < 7; n++) begin
            logic [32:0] e;
            #1;
            e = 33'(SAT_START) + 33'(n);
            if (e > 33'h0_FFFF_FFFF) e = 33'h0_FFFF_FFFF;
            check($sformatf("sat_n%0d", n), stall_cnt_s, e[31:0]);
            tick();
        end

        // Random traffic against the model.
        set_idle();
        do_reset();
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < NS; i++) begin
                ex_s[i] = W'($urandom_range(0, 7));
                id_s[i] = W'($urandom_range(0, 7));
            end
            for (int k = 0; k < NF; k++) fd[k] = W'($urandom_range(0, 7));
            ex_v  = 2'($urandom_range(0, 3));
            fwr   = 2'($urandom_range(0, 3));
            id_v  = 2'($urandom_range(0, 3));
            idd   = W'($urandom_range(0, 7));
            id_wr = 1'($urandom_range(0, 1));
            exd   = W'($urandom_range(0, 7));
            mr    = ($urandom_range(0, 3) == 0);
            li    = ($urandom_range(0, 3) == 0);
            ld    = W'($urandom_range(0, 7));
            #1;
            check($sformatf("rnd%0d_sel0", it), 32'(fwd_sel[1:0]), 32'(m_fwd(0)));
            check($sformatf("rnd%0d_sel1", it), 32'(fwd_sel[3:2]), 32'(m_fwd(1)));
            check($sformatf("rnd%0d_stall", it), 32'(stall), 32'(m_stall()));
            check($sformatf("rnd%0d_cnt", it), stall_cnt, exp_cnt);
            tick();
        end

        // Reset in the middle of a countdown.
        set_idle();
        li = 1; ld = 7;
        tick();
        li = 0; id_s[0] = 7; id_v = 1;
        tick();
        check("rstmid_busy", 32'(stall), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstmid_stall", 32'(stall), 0);
        check("rstmid_cnt", stall_cnt, 0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rstmid_release_stall", 32'(stall), 0);
        tick();
        check("rstmid_after_stall", 32'(stall), 0);
        check("rstmid_after_cnt", stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
